sensor_conditioner: RTL and testbench
=====================================

# sensor_conditioner

Front-end stage between the raw field sensors and the irrigation controller top level. It synchronises, debounces and sanity-checks the six sensor lines: high, middle and low water level, soil humidity, air humidity and temperature. The controller's error, alarm, valve, trigger and display logic only ever sees the clean, stable versions produced here. It also issues a one-cycle change strobe that downstream timers can use to restart.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised input must differ from its stable value before the stable value updates. Legal range is 2 or more.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the per-channel and warm-up counters.
- `clk`  in  1  system clock. All logic runs on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `raw_i`  in  6  raw sensors, asynchronous. Bit 0 = low level, bit 1 = middle level, bit 2 = high level, bit 3 = soil humidity, bit 4 = air humidity, bit 5 = temperature.
- `stable_o`  out  6  debounced sensor values, same bit order as `raw_i`.
- `ready_o`  out  1  high once warm-up has completed.
- `change_o`  out  1  one-cycle pulse whenever any bit of `stable_o` changes after `ready_o`.
- `level_fault_o`  out  1  debounced level triple is implausible. Only meaningful with the macro described in Configuration.

## Operation
- **Synchroniser:** each `raw_i` bit passes through a 2-flop synchroniser, giving `sync[i]`.
- **Per-channel debounce:**
  - If `sync[i]` equals `stable[i]`, counter i clears to 0.
  - Otherwise counter i increments.
  - When counter i would reach `DEBOUNCE_CYCLES`, `stable[i]` takes `sync[i]` and the counter clears in the same cycle.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is discarded.
  - Channels are fully independent. Simultaneous changes on several bits each update on their own count.
- **Warm-up FSM:**
  - States: WARMUP and RUN.
  - WARMUP counts `DEBOUNCE_CYCLES+2` cycles. On its final cycle the FSM loads `stable` directly from `sync`, sets `ready_o`, and moves to RUN.
  - No `change_o` pulse is issued for that load.
  - RUN is held until reset.
- **change_o:** asserted in the cycle after any `stable` bit update in RUN. It is a single pulse even if several bits update in the same cycle.
- **Level plausibility:** the level triple {high, middle, low} is plausible only for the values 000, 001, 011 and 111. Behaviour depends on the macro; see Configuration.
- **Counter width:** counters never wrap. They saturate by construction because they clear at the threshold.

## Timing
- **Reset values:** `stable_o`=0, `ready_o`=0, `change_o`=0, `level_fault_o`=0. Synchroniser flops, counters and FSM (WARMUP) are also reset.
- **First valid output:** `ready_o` rises `DEBOUNCE_CYCLES+2` cycles after the first clock with `rst_n`=1.
- **Input-to-output latency:** a clean edge on `raw_i` appears on `stable_o` 2 + `DEBOUNCE_CYCLES` cycles later. `change_o` follows one cycle after that.
- **Reset mid-operation:** all state clears on the next edge and warm-up restarts. Any partial debounce counts are lost.
- **Bounce during a count:** an input that reverts before the threshold clears its counter. The next differing cycle restarts the count from 1.
- **Outputs are registered.** There is no combinational path from `raw_i` to any output.

## Configuration
- Macro: `SENSOR_CONDITIONER_LEVEL_CHECK_EN`.
- **Defined:**
  - If an update would make the debounced level triple implausible, bits 2:0 of `stable_o` hold the last plausible triple.
  - `level_fault_o` is 1 for as long as the debounced triple stays implausible.
  - `change_o` does not fire for a held level update.
  - Bits 5:3 are unaffected.
- **Not defined:**
  - Bits 2:0 follow the debounce result directly, implausible or not.
  - `level_fault_o` is tied to 0.

## Structure
- **Shared package `sensor_pkg`:**
  - Bit-index constants: `LVL_LOW`, `LVL_MID`, `LVL_HIGH`, `SOIL`, `AIR`, `TEMP`.
  - `N_SENSORS`=6.
  - The plausible-triple check as a function.
- **Sub-module `debounce_ch`:** one synchroniser plus counter plus stable bit, instantiated six times. The warm-up FSM, change detection and plausibility hold stay in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset and warm-up:** `rst_n`=0 for 3 cycles, then `raw_i`=6'b000011 held. Required: `ready_o` rises 6 cycles after release with `stable_o`=000011, and `change_o` stays 0.
- **Glitch rejection:** in RUN, bit 3 is pulsed high for 3 cycles. Required: `stable_o` unchanged and `change_o` never asserts.
- **Clean edge:** bit 5 goes 0→1 and is held. Required: `stable_o[5]`=1 exactly 6 cycles later, then `change_o`=1 for one cycle.
- **Simultaneous change:** bits 4 and 5 toggle in the same cycle. Required: both update in the same cycle and a single `change_o` pulse is issued.
- **Plausibility with macro defined:** `raw_i[2:0]` goes from 011 to 101. Required: `stable_o[2:0]` stays 011 and `level_fault_o`=1. When the raw input returns to 111, `stable_o[2:0]`=111 after debounce and `level_fault_o`=0.
- **Reset mid-count:** `rst_n`=0 asserted at count 3. Required: all outputs are 0 on the next edge and warm-up restarts.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared sensor bit map, warm-up FSM states and the water-level plausibility rule.
// Used by sensor_conditioner and its per-channel debounce_ch.
package sensor_pkg;

  localparam int N_SENSORS = 6;

  localparam int LVL_LOW  = 0;
  localparam int LVL_MID  = 1;
  localparam int LVL_HIGH = 2;
  localparam int SOIL     = 3;
  localparam int AIR      = 4;
  localparam int TEMP     = 5;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } cond_state_e;

  // Triple is {high, mid, low}: a wet upper probe requires every probe below it to be wet.
  function automatic logic lvl_plausible(input logic [2:0] lvl);
    return (lvl == 3'b000) || (lvl == 3'b001) || (lvl == 3'b011) || (lvl == 3'b111);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One sensor line: 2-flop synchroniser, run-length counter and debounced stable bit.
// stable_nxt_o is the value the stable bit takes at the next edge; no backpressure.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic load_i,
  output logic stable_nxt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d   = raw_i;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // The differing run has lasted DEBOUNCE_CYCLES cycles including this one.
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_nxt_o = stable_d;

endmodule

// File: rtl/sensor_conditioner.sv
// Synchronise, debounce and sanity-check six sensor lines; edge-to-stable_o latency 2+DEBOUNCE_CYCLES, change_o one later.
// No backpressure. Define SENSOR_CONDITIONER_LEVEL_CHECK_EN to hold implausible level triples and drive level_fault_o.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] raw_i,
  output logic [5:0] stable_o,
  output logic       ready_o,
  output logic       change_o,
  output logic       level_fault_o
);

  // One extra bit: DEBOUNCE_CYCLES+1 does not fit CNT_W when DEBOUNCE_CYCLES+1 is a power of two.
  localparam int                WARM_W    = CNT_W + 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(DEBOUNCE_CYCLES + 1);

  cond_state_e            state_q, state_d;
  logic [WARM_W-1:0]      wcnt_q, wcnt_d;
  logic                   ready_q, ready_d;
  logic                   warm_load;
  logic [N_SENSORS-1:0]   deb_nxt;
  logic [N_SENSORS-1:0]   stable_q, stable_d;
  logic                   upd_q, upd_d;
  logic                   change_q, change_d;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (raw_i[g]),
      .load_i      (warm_load),
      .stable_nxt_o(deb_nxt[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ready_d   = ready_q;
    warm_load = 1'b0;
    if (state_q == WARMUP) begin
      if (wcnt_q == WARM_LAST) begin
        state_d   = RUN;
        ready_d   = 1'b1;
        warm_load = 1'b1;
        wcnt_d    = '0;
      end else begin
        wcnt_d = wcnt_q + WARM_W'(1);
      end
    end
  end

`ifdef SENSOR_CONDITIONER_LEVEL_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    stable_d = deb_nxt;
    fault_d  = 1'b0;
    if (!lvl_plausible(deb_nxt[LVL_HIGH:LVL_LOW])) begin
      stable_d[LVL_HIGH:LVL_LOW] = stable_q[LVL_HIGH:LVL_LOW];
      fault_d                    = 1'b1;
    end
    upd_d    = (state_q == RUN) && (stable_d != stable_q);
    change_d = upd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign level_fault_o = fault_q;
`else
  always_comb begin
    stable_d = deb_nxt;
    upd_d    = (state_q == RUN) && (stable_d != stable_q);
    change_d = upd_q;
  end

  assign level_fault_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= WARMUP;
      wcnt_q   <= '0;
      ready_q  <= 1'b0;
      stable_q <= '0;
      upd_q    <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ready_q  <= ready_d;
      stable_q <= stable_d;
      upd_q    <= upd_d;
      change_q <= change_d;
    end
  end

  assign stable_o = stable_q;
  assign ready_o  = ready_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4: literal checks plus a per-cycle
// behavioural model (sliding window of synchronised samples) compared on every falling edge.
module tb_sensor_conditioner;
  import sensor_pkg::*;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] raw;
  logic [5:0] stable_o;
  logic       ready_o;
  logic       change_o;
  logic       level_fault_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  sensor_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_i        (raw),
    .stable_o     (stable_o),
    .ready_o      (ready_o),
    .change_o     (change_o),
    .level_fault_o(level_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk6(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Values of the form 2^k-1 are exactly the "filled from the bottom" level patterns.
  function automatic logic plausible(input logic [2:0] t);
    return (t & (t + 3'd1)) == 3'd0;
  endfunction

  // Model: raw reaches the comparison point two edges late; a bit flips once its last D
  // synchronised samples all disagree with it; warm-up loads on the (D+2)th edge after release.
  logic [5:0] p1, p2, sync_m, deb, out_m, m_stable;
  logic [5:0] hist [D];
  logic       m_ready, m_change, m_pend, m_fault, load_m, all_diff, fault_m;
  int         since_rel;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      p1 = '0; p2 = '0; deb = '0; m_stable = '0;
      m_ready = 1'b0; m_change = 1'b0; m_pend = 1'b0; m_fault = 1'b0;
      since_rel = 0;
      for (int k = 0; k < D; k++) hist[k] = '0;
    end else begin
      sync_m = p2;
      p2     = p1;
      p1     = raw;
      for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sync_m;
      since_rel++;
      load_m = !m_ready && (since_rel == D + 2);
      if (load_m) begin
        deb = sync_m;
      end else begin
        for (int i = 0; i < 6; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++) if (hist[k][i] == deb[i]) all_diff = 1'b0;
          if (all_diff) deb[i] = ~deb[i];
        end
      end
      out_m   = deb;
      fault_m = 1'b0;
`ifdef SENSOR_CONDITIONER_LEVEL_CHECK_EN
      if (!plausible(deb[2:0])) begin
        out_m[2:0] = m_stable[2:0];
        fault_m    = 1'b1;
      end
`endif
      m_change = m_pend;
      m_pend   = m_ready && (out_m != m_stable);
      m_stable = out_m;
      m_fault  = fault_m;
      if (load_m) m_ready = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk6("model_stable", stable_o, m_stable);
      chk1("model_ready", ready_o, m_ready);
      chk1("model_change", change_o, m_change);
      chk1("model_fault", level_fault_o, m_fault);
    end
  end

  initial begin
    rst_n = 1'b0;
    raw   = 6'b000000;
    tick(3);
    chk_en = 1'b1;
    chk6("rst_stable", stable_o, 6'b000000);
    chk1("rst_ready", ready_o, 1'b0);
    chk1("rst_change", change_o, 1'b0);
    chk1("rst_fault", level_fault_o, 1'b0);

    // Warm-up
    rst_n = 1'b1;
    raw   = 6'b000011;
    tick(5);
    chk1("warm_ready_early", ready_o, 1'b0);
    chk6("warm_stable_early", stable_o, 6'b000000);
    tick(1);
    chk1("warm_ready", ready_o, 1'b1);
    chk6("warm_stable", stable_o, 6'b000011);
    chk1("warm_change", change_o, 1'b0);
    tick(1);
    chk1("warm_no_pulse", change_o, 1'b0);
    tick(2);

    // Glitch of D-1 cycles
    raw[SOIL] = 1'b1;
    tick(3);
    raw[SOIL] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk1("glitch_change", change_o, 1'b0);
    end
    chk6("glitch_stable", stable_o, 6'b000011);

    // Bounce restarts the count
    raw[SOIL] = 1'b1;
    tick(2);
    raw[SOIL] = 1'b0;
    tick(1);
    raw[SOIL] = 1'b1;
    tick(5);
    chk6("bounce_hold", stable_o, 6'b000011);
    tick(1);
    chk6("bounce_upd", stable_o, 6'b001011);
    tick(1);
    chk1("bounce_change", change_o, 1'b1);
    tick(1);
    chk1("bounce_change_end", change_o, 1'b0);
    tick(2);

    // Clean edge on temperature
    raw[TEMP] = 1'b1;
    tick(5);
    chk6("edge_hold", stable_o, 6'b001011);
    tick(1);
    chk6("edge_upd", stable_o, 6'b101011);
    chk1("edge_change_same", change_o, 1'b0);
    tick(1);
    chk1("edge_change", change_o, 1'b1);
    tick(1);
    chk1("edge_change_end", change_o, 1'b0);
    tick(2);

    // Air and temperature toggle together
    raw[AIR]  = 1'b1;
    raw[TEMP] = 1'b0;
    tick(5);
    chk6("simul_hold", stable_o, 6'b101011);
    tick(1);
    chk6("simul_upd", stable_o, 6'b011011);
    chk1("simul_change_same", change_o, 1'b0);
    tick(1);
    chk1("simul_change", change_o, 1'b1);
    tick(1);
    chk1("simul_change_end", change_o, 1'b0);
    tick(2);

    // Level triple 011 -> 101 -> 111
    raw[LVL_HIGH:LVL_LOW] = 3'b101;
    tick(6);
`ifdef SENSOR_CONDITIONER_LEVEL_CHECK_EN
    chk6("lvl_held", stable_o, 6'b011011);
    chk1("lvl_fault", level_fault_o, 1'b1);
    tick(1);
    chk1("lvl_held_change", change_o, 1'b0);
`else
    chk6("lvl_follow", stable_o, 6'b011101);
    chk1("lvl_fault_tied", level_fault_o, 1'b0);
    tick(1);
    chk1("lvl_follow_change", change_o, 1'b1);
`endif
    tick(2);
    raw[LVL_MID] = 1'b1;
    tick(6);
    chk6("lvl_full", stable_o, 6'b011111);
    chk1("lvl_fault_clear", level_fault_o, 1'b0);
    tick(1);
    chk1("lvl_full_change", change_o, 1'b1);
    tick(2);

    // Reset in the middle of a count
    raw[AIR] = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk6("midrst_stable", stable_o, 6'b000000);
    chk1("midrst_ready", ready_o, 1'b0);
    chk1("midrst_change", change_o, 1'b0);
    chk1("midrst_fault", level_fault_o, 1'b0);
    rst_n = 1'b1;
    tick(5);
    chk1("rewarm_ready_early", ready_o, 1'b0);
    tick(1);
    chk1("rewarm_ready", ready_o, 1'b1);
    chk6("rewarm_stable", stable_o, 6'b001111);
    tick(1);
    chk1("rewarm_no_pulse", change_o, 1'b0);
    tick(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
